// File: rtl/out_port_uart_tx.sv
// rtl/out_port_uart_tx.sv - CPU output-port word FIFO feeding an LS-byte-first UART transmitter
// Optional macro OUT_UART_PARITY_EN adds an even-parity bit after each data byte.
module out_port_uart_tx #(
  parameter int DATA_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          out_ld_i,
  input  logic [DATA_WIDTH-1:0]         out_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overflow_o
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TW     = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]    DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0]  TICK_C     = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]  LAST_BYTE  = BW'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef OUT_UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [TW-1:0]         timer_q;
  logic [2:0]            bit_idx_q;
  logic [BW-1:0]         byte_idx_q;
`ifdef OUT_UART_PARITY_EN
  logic                  parity_q;
`endif

  logic        push_ok, pop, tick, last_byte, word_done, next_idle;
  logic [AW:0] count_n;

  // Pointers carry one extra wrap bit, so the difference is the occupancy.
  assign count_o   = wr_ptr - rd_ptr;
  assign full_o    = (count_o == DEPTH_C);
  assign push_ok   = out_ld_i & ~full_o;
  assign pop       = (state == IDLE) & (count_o != '0);
  assign tick      = (timer_q == TICK_C);
  assign last_byte = (byte_idx_q == LAST_BYTE);
  assign word_done = (state == STOP) & tick & last_byte;
  assign next_idle = ((state == IDLE) & ~pop) | word_done;
  assign count_n   = count_o + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= out_i;
  end

  // tx_o is driven from the current state, so the line lags the state by one cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      state      <= IDLE;
      tx_o       <= 1'b1;
      busy_o     <= 1'b0;
      overflow_o <= 1'b0;
      shift_q    <= '0;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
`ifdef OUT_UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (out_ld_i && full_o) overflow_o <= 1'b1;
      busy_o <= ~next_idle | (count_n != '0);

      case (state)
        IDLE: begin
          tx_o    <= 1'b1;
          timer_q <= '0;
          if (pop) begin
            shift_q    <= mem[rd_ptr[AW-1:0]];
            rd_ptr     <= rd_ptr + 1'b1;
            byte_idx_q <= '0;
            state      <= START;
          end
        end
        START: begin
          tx_o <= 1'b0;
          if (tick) begin
            timer_q   <= '0;
            bit_idx_q <= '0;
`ifdef OUT_UART_PARITY_EN
            parity_q  <= 1'b0;
`endif
            state     <= DATA;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DATA: begin
          tx_o <= shift_q[0];
          if (tick) begin
            timer_q   <= '0;
            shift_q   <= shift_q >> 1;
`ifdef OUT_UART_PARITY_EN
            parity_q  <= parity_q ^ shift_q[0];
`endif
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
`ifdef OUT_UART_PARITY_EN
        PARITY: begin
          tx_o <= parity_q;
          if (tick) begin
            timer_q <= '0;
            state   <= STOP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
`endif
        STOP: begin
          tx_o <= 1'b1;
          if (tick) begin
            timer_q <= '0;
            if (last_byte) begin
              state <= IDLE;
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
              state      <= START;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          tx_o  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_uart_tx.sv
// tb/tb_out_port_uart_tx.sv - scoreboard bench for out_port_uart_tx
module tb_out_port_uart_tx;
  localparam int DW  = 16;
  localparam int FD  = 4;
  localparam int CPB = 16;
  localparam int NB  = DW / 8;
`ifdef OUT_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int WORD_CYC  = NB * FB * CPB;
  localparam int RST_EDGE  = WORD_CYC + 3 + CPB + 4 * CPB;
  localparam int DRAIN_LIM = 6 * (WORD_CYC + 1) + 100;

  logic                  Clock_TB = 1'b0;
  logic                  reset_i, out_ld_i;
  logic [DW-1:0]         out_i;
  logic                  tx_o, busy_o, full_o, overflow_o;
  logic [$clog2(FD):0]   count_o;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  bit         mon_en   = 1'b1;

  always #5 Clock_TB = ~Clock_TB;

  out_port_uart_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .CLKS_PER_BIT(CPB)) dut (
    .clk_i(Clock_TB), .reset_i(reset_i), .out_ld_i(out_ld_i), .out_i(out_i),
    .tx_o(tx_o), .busy_o(busy_o), .full_o(full_o), .count_o(count_o),
    .overflow_o(overflow_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock_TB);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w, input bit sent);
    out_ld_i = 1'b1;
    out_i    = w;
    if (sent)
      for (int b = 0; b < NB; b++) exp_q.push_back(w[8*b +: 8]);
    step();
    out_ld_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    repeat (2) step();
    reset_i = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((busy_o || exp_q.size() != 0) && c < DRAIN_LIM) begin
      step();
      c++;
    end
    check("drain_busy", busy_o, 0);
    check("drain_scoreboard", exp_q.size(), 0);
  endtask

  // UART receiver: samples each bit at its midpoint and pops the scoreboard.
  initial begin : monitor
    logic [7:0] b;
    logic       st, stp;
`ifdef OUT_UART_PARITY_EN
    logic       par;
`endif
    forever begin
      @(negedge Clock_TB);
      if (tx_o === 1'b0) begin
        repeat (7) @(negedge Clock_TB);
        st = tx_o;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge Clock_TB);
          b[i] = tx_o;
        end
`ifdef OUT_UART_PARITY_EN
        repeat (CPB) @(negedge Clock_TB);
        par = tx_o;
`endif
        repeat (CPB) @(negedge Clock_TB);
        stp = tx_o;
        if (mon_en) begin
          check("start_bit", st, 0);
          check("stop_bit", stp, 1);
          check("byte_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("rx_byte", b, e);
`ifdef OUT_UART_PARITY_EN
            check("parity_bit", par, ^e);
`endif
          end
        end
      end
    end
  end

  initial begin : stim
    int cyc;
    reset_i  = 1'b0;
    out_ld_i = 1'b0;
    out_i    = '0;

    // Reset state
    do_reset();
    check("rst_tx", tx_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_count", count_o, 0);
    check("rst_full", full_o, 0);
    check("rst_overflow", overflow_o, 0);

    // Single word: latency and word time
    push_word(16'hA55A, 1'b1);
    check("single_count", count_o, 1);
    check("single_busy", busy_o, 1);
    step();
    check("tx_high_n1", tx_o, 1);
    step();
    check("tx_fall_n2", tx_o, 0);
    cyc = 2;
    while (busy_o && cyc < 1000) begin
      step();
      cyc++;
    end
    check("busy_drop_cycles", cyc, WORD_CYC + 1);
    wait_drain();

    // Six back-to-back writes: the sixth is dropped
    for (int k = 1; k <= 6; k++) push_word(DW'(k), k <= 5);
    check("burst_full", full_o, 1);
    check("burst_overflow", overflow_o, 1);
    check("burst_count", count_o, FD);
    wait_drain();
    check("overflow_sticky", overflow_o, 1);
    check("drained_count", count_o, 0);

    // Push while full on the same edge as a pop
    do_reset();
    check("rst2_overflow", overflow_o, 0);
    for (int k = 0; k < 5; k++) push_word(DW'(16'hC310 + k), 1'b1);
    repeat (WORD_CYC - 3) step();
    check("prepop_full", full_o, 1);
    check("prepop_count", count_o, FD);
    check("prepop_overflow", overflow_o, 0);
    push_word(16'hDEAD, 1'b0);
    check("poppush_count", count_o, FD - 1);
    check("poppush_overflow", overflow_o, 1);
    check("poppush_full", full_o, 0);
    wait_drain();

    // Reset in the middle of the second word's data bits
    do_reset();
    push_word(16'h4B2D, 1'b1);
    push_word(16'h0000, 1'b0);
    push_word(16'h1234, 1'b0);
    repeat (WORD_CYC - 3) step();
    check("first_word_received", exp_q.size(), 0);
    mon_en = 1'b0;
    repeat (RST_EDGE - 1 - WORD_CYC) step();
    check("prerst_count", count_o, 1);
    check("prerst_tx_low", tx_o, 0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("midrst_tx", tx_o, 1);
    check("midrst_count", count_o, 0);
    check("midrst_busy", busy_o, 0);
    repeat (250) step();
    mon_en = 1'b1;
    push_word(16'h00FF, 1'b1);
    step();
    check("postrst_tx_n1", tx_o, 1);
    step();
    check("postrst_tx_n2", tx_o, 0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
